// File: rtl/tuner_pkg.sv
// Shared definitions for the note tuner front end.
//   fm_state_e     : freq_meter control states
//   FREQ_W         : width of the frequency word passed to the tuner
//   CLK_HZ_DEFAULT : default system clock frequency in Hz
package tuner_pkg;

  // Frequency word width, shared with the tuner's note frequency input.
  localparam int unsigned FREQ_W = 64;

  // Default system clock.
  localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StMeasure,
    StDivide,
    StOutput
  } fm_state_e;

endpackage : tuner_pkg

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, FREQ_W cycles per divide.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   start    : load dividend/divisor and begin dividing
//   abort    : cancel any divide in progress (wins over start)
//   dividend : numerator, sampled on start
//   divisor  : denominator, sampled on start; caller guarantees non-zero
//   quotient : result, valid the cycle after done
//   done     : high during the final iteration cycle
module seq_divider
  import tuner_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [FREQ_W-1:0] dividend,
  input  logic [FREQ_W-1:0] divisor,
  output logic [FREQ_W-1:0] quotient,
  output logic              done
);

  localparam int unsigned       STEP_W    = $clog2(FREQ_W);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(FREQ_W - 1);

  logic [FREQ_W-1:0] rem_q, rem_d;
  logic [FREQ_W-1:0] quo_q, quo_d;
  logic [FREQ_W-1:0] dvs_q, dvs_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              run_q, run_d;

  // Partial remainder shifted left by one with the next dividend bit brought in,
  // and the trial subtraction of the divisor from it.
  logic [FREQ_W:0]   shifted;
  logic [FREQ_W:0]   trial;

  always_comb begin
    shifted = {rem_q, quo_q[FREQ_W-1]};
    trial   = shifted - {1'b0, dvs_q};

    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    step_d = step_q;
    run_d  = run_q;

    if (abort) begin
      run_d  = 1'b0;
      step_d = '0;
    end else if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
      step_d = '0;
      run_d  = 1'b1;
    end else if (run_q) begin
      // The quotient register doubles as the dividend shift register: dividend
      // bits leave at the top while quotient bits enter at the bottom.
      if (!trial[FREQ_W]) begin
        rem_d = trial[FREQ_W-1:0];
        quo_d = {quo_q[FREQ_W-2:0], 1'b1};
      end else begin
        rem_d = shifted[FREQ_W-1:0];
        quo_d = {quo_q[FREQ_W-2:0], 1'b0};
      end
      step_d = step_q + 1'b1;
      if (step_q == LAST_STEP) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      step_q <= '0;
      run_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      step_q <= step_d;
      run_q  <= run_d;
    end
  end

  assign quotient = quo_q;
  assign done     = run_q && (step_q == LAST_STEP) && !abort;

endmodule : seq_divider

// File: rtl/freq_meter.sv
// Fundamental frequency meter for a squared audio signal. Counts clock cycles across
// AVG_PERIODS input periods, then divides to get integer Hz rounded to nearest.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   on         : enable; low forces idle and clears the result
//   sig_in     : asynchronous squared audio input
//   freq_out   : measured frequency in Hz, held between strobes
//   freq_valid : one-cycle strobe when freq_out/no_signal update
//   no_signal  : last result came from a timeout
//   busy       : divider running
module freq_meter
  import tuner_pkg::*;
#(
  parameter int unsigned CLK_HZ      = CLK_HZ_DEFAULT,
  parameter int unsigned AVG_PERIODS = 4,
  parameter int unsigned TIMEOUT_CYC = 10_000_000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              on,
  input  logic              sig_in,
  output logic [FREQ_W-1:0] freq_out,
  output logic              freq_valid,
  output logic              no_signal,
  output logic              busy
);

  // Elaboration-time parameter checks.
  if (AVG_PERIODS < 1 || AVG_PERIODS > 255) begin : g_bad_avg
    $error("freq_meter: AVG_PERIODS must be in 1..255");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("freq_meter: TIMEOUT_CYC must be at least 1");
  end
  if (CNT_W < 1 || CNT_W > 63) begin : g_bad_cnt_w
    $error("freq_meter: CNT_W must be in 1..63");
  end else if ((64'(AVG_PERIODS) * 64'(TIMEOUT_CYC)) >= (64'd1 << CNT_W)) begin : g_cnt_overflow
    $error("freq_meter: AVG_PERIODS*TIMEOUT_CYC does not fit in CNT_W bits");
  end

  localparam logic [FREQ_W-1:0] NUMER   = 64'(AVG_PERIODS) * 64'(CLK_HZ);
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]        AVG_N   = 8'(AVG_PERIODS);

  // sync_q[0], sync_q[1] form the synchronizer; sync_q[2] is the edge-detect delay.
  logic [2:0]        sync_q, sync_d;
  logic              edge_det;

  fm_state_e         state_q, state_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [7:0]        edges_q, edges_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              valid_q, valid_d;
  logic              nosig_q, nosig_d;
  logic              busy_q, busy_d;

  logic              timeout_hit;
  logic              div_start;
  logic              div_abort;
  logic              div_done;
  logic [FREQ_W-1:0] div_dividend;
  logic [FREQ_W-1:0] div_divisor;
  logic [FREQ_W-1:0] div_quotient;

  assign sync_d   = {sync_q[1:0], sig_in};
  assign edge_det = sync_q[1] & ~sync_q[2];

  // period_q counts from 0, so hitting TIMEOUT_CYC-1 means this cycle completes
  // TIMEOUT_CYC cycles without an edge.
  assign timeout_hit = (period_q == TO_LAST);

  // The terminating edge cycle is counted in D, hence the +1. Adding D/2 before
  // truncating division rounds to nearest.
  assign div_divisor  = 64'(total_q) + 64'd1;
  assign div_dividend = NUMER + (div_divisor >> 1);

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    total_d   = total_q;
    edges_d   = edges_q;
    freq_d    = freq_q;
    valid_d   = 1'b0;
    nosig_d   = nosig_q;
    div_start = 1'b0;
    div_abort = 1'b0;

    if (!on) begin
      // Disable wins over everything, including a terminating edge this cycle.
      state_d   = StIdle;
      period_d  = '0;
      total_d   = '0;
      edges_d   = '0;
      freq_d    = '0;
      nosig_d   = 1'b0;
      div_abort = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = StArm;
          period_d = '0;
          total_d  = '0;
          edges_d  = '0;
        end

        StArm: begin
          if (edge_det) begin
            state_d  = StMeasure;
            period_d = '0;
            total_d  = '0;
            edges_d  = '0;
          end else if (timeout_hit) begin
            freq_d   = '0;
            nosig_d  = 1'b1;
            valid_d  = 1'b1;
            period_d = '0;
            total_d  = '0;
            edges_d  = '0;
          end else begin
            period_d = period_q + 1'b1;
          end
        end

        StMeasure: begin
          total_d = total_q + 1'b1;
          if (edge_det) begin
            // An edge wins over a coincident timeout.
            period_d = '0;
            if (edges_q + 8'd1 == AVG_N) begin
              state_d   = StDivide;
              div_start = 1'b1;
            end else begin
              edges_d = edges_q + 8'd1;
            end
          end else if (timeout_hit) begin
            state_d  = StArm;
            freq_d   = '0;
            nosig_d  = 1'b1;
            valid_d  = 1'b1;
            period_d = '0;
            total_d  = '0;
            edges_d  = '0;
          end else begin
            period_d = period_q + 1'b1;
          end
        end

        StDivide: begin
          if (div_done) begin
            state_d = StOutput;
          end
        end

        StOutput: begin
          freq_d   = div_quotient;
          nosig_d  = 1'b0;
          valid_d  = 1'b1;
          state_d  = StArm;
          period_d = '0;
          total_d  = '0;
          edges_d  = '0;
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end

    busy_d = (state_d == StDivide);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      state_q  <= StIdle;
      period_q <= '0;
      total_q  <= '0;
      edges_q  <= '0;
      freq_q   <= '0;
      valid_q  <= 1'b0;
      nosig_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      period_q <= period_d;
      total_q  <= total_d;
      edges_q  <= edges_d;
      freq_q   <= freq_d;
      valid_q  <= valid_d;
      nosig_q  <= nosig_d;
      busy_q   <= busy_d;
    end
  end

  seq_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_quotient),
    .done     (div_done)
  );

  assign freq_out   = freq_q;
  assign freq_valid = valid_q;
  assign no_signal  = nosig_q;
  assign busy       = busy_q;

endmodule : freq_meter

// File: tb/tb_freq_meter.sv
module tb_freq_meter;

  localparam int unsigned CLK_HZ  = 1_000_000;
  localparam int unsigned AVG     = 4;
  // Shortened timeout; still longer than the slowest tone used here.
  localparam int unsigned TIMEOUT = 3_000;
  // sig_in rise to strobe: 2 sync cycles + 64 divide cycles + 2.
  localparam longint unsigned LAT = 68;

  logic        clk = 1'b0;
  logic        rst;
  logic        on;
  logic        sig_in;
  logic [63:0] freq_out;
  logic        freq_valid;
  logic        no_signal;
  logic        busy;

  freq_meter #(
    .CLK_HZ      (CLK_HZ),
    .AVG_PERIODS (AVG),
    .TIMEOUT_CYC (TIMEOUT),
    .CNT_W       (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .on         (on),
    .sig_in     (sig_in),
    .freq_out   (freq_out),
    .freq_valid (freq_valid),
    .no_signal  (no_signal),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  longint unsigned cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  typedef struct {
    logic [63:0]     freq;
    logic            nosig;
    int unsigned     busy_run;
    longint unsigned at;
  } strobe_t;

  strobe_t         strobes[$];
  longint unsigned rises[$];
  int unsigned     busy_cnt      = 0;
  int unsigned     last_busy_run = 0;

  initial forever begin
    @(negedge clk);
    if (busy === 1'b1) begin
      busy_cnt++;
    end else if (busy_cnt != 0) begin
      last_busy_run = busy_cnt;
      busy_cnt      = 0;
    end
    if (freq_valid === 1'b1) begin
      strobes.push_back('{freq: freq_out, nosig: no_signal, busy_run: last_busy_run, at: cyc});
    end
  end

  // Reference: AVG periods in D clock cycles, rounded to nearest Hz.
  function automatic logic [63:0] ref_freq(input longint unsigned d);
    longint unsigned num;
    num = longint'(AVG) * longint'(CLK_HZ);
    return (num + d / 2) / d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_strobe(input string name, input int idx, input logic [63:0] exp_freq,
                              input logic exp_nosig);
    check({name, "_present"}, {63'd0, strobes.size() > idx}, 64'd1);
    if (strobes.size() > idx) begin
      check({name, "_freq"}, strobes[idx].freq, exp_freq);
      check({name, "_nosig"}, {63'd0, strobes[idx].nosig}, {63'd0, exp_nosig});
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rise();
    sig_in = 1'b1;
    rises.push_back(cyc);
  endtask

  task automatic drive_period(input int unsigned p, input int unsigned hi);
    rise();
    step(hi);
    sig_in = 1'b0;
    step(p - hi);
  endtask

  task automatic drive_tone(input int unsigned p, input int unsigned n);
    for (int k = 0; k < int'(n); k++) drive_period(p, p / 2);
  endtask

  task automatic restart();
    on     = 1'b0;
    sig_in = 1'b0;
    step(2);
    on = 1'b1;
    step(3);
    strobes.delete();
    rises.delete();
  endtask

  typedef struct {
    int unsigned period;
    logic [63:0] exp_freq;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{period: 2273, exp_freq: 64'd440};
    vecs[1] = '{period: 1000, exp_freq: 64'd1000};
    vecs[2] = '{period: 250,  exp_freq: 64'd4000};
    vecs[3] = '{period: 137,  exp_freq: 64'd7299};
    vecs[4] = '{period: 6,    exp_freq: 64'd166667};
    vecs[5] = '{period: 3,    exp_freq: 64'd333333};
    vecs[6] = '{period: 2,    exp_freq: 64'd500000};

    rst    = 1'b0;
    on     = 1'b0;
    sig_in = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_freq_out", freq_out, 64'd0);
    check("rst_valid", {63'd0, freq_valid}, 64'd0);
    check("rst_nosig", {63'd0, no_signal}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    step(5);
    check("idle_no_strobe", 64'(strobes.size()), 64'd0);

    // Fixed tones: frequency, one-cycle strobe, busy length and latency.
    for (int i = 0; i < 7; i++) begin
      string nm;
      nm = $sformatf("tone_p%0d", vecs[i].period);
      restart();
      drive_tone(vecs[i].period, 5);
      step(80);
      check({nm, "_count"}, 64'(strobes.size()), 64'd1);
      check_strobe(nm, 0, vecs[i].exp_freq, 1'b0);
      if (strobes.size() > 0) begin
        check({nm, "_busy_run"}, 64'(strobes[0].busy_run), 64'd64);
        check({nm, "_latency"}, strobes[0].at - rises[4], LAT);
      end
    end

    // No input at all: timeout strobes every TIMEOUT cycles after ARM entry.
    begin
      longint unsigned t_on;
      on     = 1'b0;
      sig_in = 1'b0;
      step(2);
      strobes.delete();
      on   = 1'b1;
      t_on = cyc;
      step(2 * TIMEOUT + 10);
      check("arm_to_count", 64'(strobes.size()), 64'd2);
      check_strobe("arm_to0", 0, 64'd0, 1'b1);
      check_strobe("arm_to1", 1, 64'd0, 1'b1);
      if (strobes.size() > 1) begin
        check("arm_to0_time", strobes[0].at - t_on, 64'(TIMEOUT + 1));
        check("arm_to1_time", strobes[1].at - strobes[0].at, 64'(TIMEOUT));
      end
    end

    // Tone stops after two edges mid-measure, then resumes.
    begin
      restart();
      drive_period(2273, 1136);
      rise();
      step(1136);
      sig_in = 1'b0;
      step(TIMEOUT);
      check_strobe("mid_to", 0, 64'd0, 1'b1);
      if (strobes.size() > 0) begin
        // Edge seen 2 cycles after the rise; period count restarts the cycle after.
        check("mid_to_time", strobes[0].at - rises[1], 64'(TIMEOUT + 3));
      end
      check("mid_to_nosig_hold", {63'd0, no_signal}, 64'd1);
      drive_tone(2273, 5);
      step(80);
      check("mid_to_count", 64'(strobes.size()), 64'd2);
      check_strobe("mid_rearm", 1, ref_freq(4 * 2273), 1'b0);
    end

    // Randomized periods and duty cycles against the reference model.
    for (int r = 0; r < 2; r++) begin
      int unsigned per[15];
      logic [63:0] expf[3];
      longint unsigned d;
      restart();
      for (int k = 0; k < 15; k++) per[k] = $urandom_range(400, 100);
      // Each measurement uses five consecutive rises; the next one starts fresh.
      for (int m = 0; m < 3; m++) begin
        d = 0;
        for (int k = 0; k < 4; k++) d += per[5 * m + k];
        expf[m] = ref_freq(d);
      end
      for (int k = 0; k < 15; k++) drive_period(per[k], $urandom_range(per[k] - 1, 1));
      step(100);
      check($sformatf("rand%0d_count", r), 64'(strobes.size()), 64'd3);
      for (int m = 0; m < 3; m++) begin
        check_strobe($sformatf("rand%0d_m%0d", r, m), m, expf[m], 1'b0);
      end
    end

    // Asynchronous reset during a divide.
    begin
      restart();
      drive_tone(2273, 5);
      step(80);
      check_strobe("pre_rst", 0, 64'd440, 1'b0);
      drive_tone(2273, 4);
      rise();
      step(30);
      check("pre_rst_busy", {63'd0, busy}, 64'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_freq_out", freq_out, 64'd0);
      check("arst_valid", {63'd0, freq_valid}, 64'd0);
      check("arst_nosig", {63'd0, no_signal}, 64'd0);
      check("arst_busy", {63'd0, busy}, 64'd0);
      step(2);
      sig_in = 1'b0;
      rst    = 1'b0;
      step(2);
      strobes.delete();
      rises.delete();
      drive_tone(2273, 5);
      step(80);
      check("post_rst_count", 64'(strobes.size()), 64'd1);
      check_strobe("post_rst", 0, 64'd440, 1'b0);
    end

    // Enable dropped during a divide.
    begin
      restart();
      drive_tone(2273, 5);
      step(80);
      check_strobe("pre_off", 0, 64'd440, 1'b0);
      drive_tone(2273, 4);
      rise();
      step(30);
      check("pre_off_busy", {63'd0, busy}, 64'd1);
      check("pre_off_hold", freq_out, 64'd440);
      on = 1'b0;
      step(1);
      check("off_busy", {63'd0, busy}, 64'd0);
      check("off_freq_out", freq_out, 64'd0);
      check("off_nosig", {63'd0, no_signal}, 64'd0);
      step(100);
      check("off_no_strobe", 64'(strobes.size()), 64'd1);
      sig_in = 1'b0;
      on     = 1'b1;
      step(3);
      strobes.delete();
      rises.delete();
      drive_tone(2273, 5);
      step(80);
      check("reon_count", 64'(strobes.size()), 64'd1);
      check_strobe("reon", 0, 64'd440, 1'b0);
      if (strobes.size() > 0) begin
        check("reon_busy_run", 64'(strobes[0].busy_run), 64'd64);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_freq_meter
